// File: rtl/highprec_wr_packer_pkg.sv
// Shared constants and types for the high-precision RAM write path.
// Optional build macro used by highprec_wr_packer: HIGHPREC_WR_PACKER_STATS_EN.
package highprec_pkg;

  localparam int BDADDR = 12;
  localparam int BDWORD = 2048;
  localparam int BDBEAT = 256;
  localparam int NBEAT  = BDWORD / BDBEAT;

  // Address type shared with the RAM instantiation
  typedef logic [BDADDR-1:0] bd_addr_t;

  // Packer control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } packer_state_t;

endpackage

// File: rtl/highprec_wr_packer_if.sv
// Beat-stream input and RAM write port of the high-precision packer.
// The slave modport is the packer side; the master modport is the
// environment that supplies beats and receives RAM writes.
interface highprec_wr_packer_if #(
  parameter int BDADDR = highprec_pkg::BDADDR,
  parameter int BDWORD = highprec_pkg::BDWORD,
  parameter int BDBEAT = highprec_pkg::BDBEAT
);

  logic              in_valid;
  logic              in_ready;
  logic [BDBEAT-1:0] in_data;
  logic              in_last;
  logic              wr_en;
  logic [BDADDR-1:0] wr_addr;
  logic [BDWORD-1:0] wr_word;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_word
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_word
  );

endinterface

// File: rtl/highprec_wr_packer_beat_assembler.sv
// highprec_beat_assembler: collects BDBEAT-wide beats into one BDWORD word.
// Beat 0 lands in the LSBs; a word closes on the last lane or on beat_last,
// in which case lanes above the closing beat read as zero.
module highprec_beat_assembler #(
  parameter int BDWORD = highprec_pkg::BDWORD,
  parameter int BDBEAT = highprec_pkg::BDBEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat_fire,
  input  logic [BDBEAT-1:0] beat_data,
  input  logic              beat_last,
  output logic              word_complete,
  output logic [BDWORD-1:0] word
);

  localparam int NBEAT = BDWORD / BDBEAT;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  logic [BW-1:0]     beat_q;
  logic [BDWORD-1:0] asm_q;

  assign word_complete = beat_fire && (beat_last || (beat_q == BW'(NBEAT - 1)));

  // Present the finished word: stored lanes, current beat in its lane, zeros above
  always_comb begin
    word = '0;
    for (int l = 0; l < NBEAT; l++) begin
      if (BW'(l) == beat_q) begin
        word[l*BDBEAT +: BDBEAT] = beat_data;
      end else if (BW'(l) < beat_q) begin
        word[l*BDBEAT +: BDBEAT] = asm_q[l*BDBEAT +: BDBEAT];
      end
    end
  end

  // Beat counter and assembly register, emptied at frame start and after each word
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      beat_q <= '0;
      asm_q  <= '0;
    end else if (beat_fire) begin
      if (word_complete) begin
        beat_q <= '0;
        asm_q  <= '0;
      end else begin
        for (int l = 0; l < NBEAT; l++) begin
          if (BW'(l) == beat_q) begin
            asm_q[l*BDBEAT +: BDBEAT] <= beat_data;
          end
        end
        beat_q <= beat_q + BW'(1);
      end
    end
  end

endmodule

// File: rtl/highprec_wr_packer.sv
// highprec_wr_packer: packs upstream beats into RAM words and writes a frame
// of consecutive addresses, pulsing done when the frame is complete.
// Define HIGHPREC_WR_PACKER_STATS_EN to add the saturating stat_words counter.
module highprec_wr_packer #(
  parameter int BDADDR = highprec_pkg::BDADDR,
  parameter int BDWORD = highprec_pkg::BDWORD,
  parameter int BDBEAT = highprec_pkg::BDBEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [BDADDR-1:0] cfg_base,
  input  logic [BDADDR:0]   cfg_len,
  output logic              busy,
  output logic              done,
`ifdef HIGHPREC_WR_PACKER_STATS_EN
  output logic [31:0]       stat_words,
`endif
  highprec_wr_packer_if.slave bus
);

  import highprec_pkg::*;

  packer_state_t     state_q, state_d;
  logic [BDADDR-1:0] addr_q;
  logic [BDADDR:0]   remaining_q;
  logic              wr_en_q, done_q;
  logic [BDADDR-1:0] wr_addr_q;
  logic [BDWORD-1:0] wr_word_q;
  logic              run, start_frame, start_empty;
  logic              beat_fire, word_complete, frame_end;
  logic [BDWORD-1:0] asm_word;

  highprec_beat_assembler #(
    .BDWORD(BDWORD),
    .BDBEAT(BDBEAT)
  ) u_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start_frame),
    .beat_fire    (beat_fire),
    .beat_data    (bus.in_data),
    .beat_last    (bus.in_last),
    .word_complete(word_complete),
    .word         (asm_word)
  );

  assign beat_fire = bus.in_valid && run;
  assign frame_end = word_complete && (bus.in_last || (remaining_q == (BDADDR+1)'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a non-empty start opens a frame, the final word closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start && (cfg_len != '0)) state_d = RUN;
      RUN:     if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs and start qualification (starts only count in IDLE)
  always_comb begin
    run          = (state_q == RUN);
    busy         = run;
    bus.in_ready = run;
    start_frame  = (state_q == IDLE) && cfg_start && (cfg_len != '0);
    start_empty  = (state_q == IDLE) && cfg_start && (cfg_len == '0);
  end

  // Frame address/length tracking and the registered RAM write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_word_q   <= '0;
    end else begin
      wr_en_q <= word_complete;
      done_q  <= start_empty || frame_end;
      if (start_frame) begin
        addr_q      <= cfg_base;
        remaining_q <= cfg_len;
      end else if (word_complete) begin
        addr_q      <= addr_q + BDADDR'(1);
        remaining_q <= remaining_q - (BDADDR+1)'(1);
      end
      if (word_complete) begin
        wr_addr_q <= addr_q;
        wr_word_q <= asm_word;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_word = wr_word_q;
  assign done        = done_q;

`ifdef HIGHPREC_WR_PACKER_STATS_EN
  // Saturating count of issued RAM writes
  always_ff @(posedge clk) begin
    if (!rst_n)                          stat_words <= '0;
    else if (wr_en_q && (stat_words != '1)) stat_words <= stat_words + 32'd1;
  end
`endif

endmodule
